// File: rtl/toy_pack.sv
// Shared icache types: dataram read payload, read source encoding and
// read-scheduler FSM states.
package toy_pack;

    localparam int ICACHE_WAY_WIDTH       = 2;
    localparam int ICACHE_INDEX_WIDTH     = 6;
    localparam int ICACHE_REQ_TXNID_WIDTH = 4;

    typedef struct packed {
        logic [ICACHE_WAY_WIDTH-1:0]       way;
        logic [ICACHE_INDEX_WIDTH-1:0]     index;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    } dataram_rd_pld_t;

    typedef enum logic [1:0] {
        SRC_HIT  = 2'd0,
        SRC_MSHR = 2'd1,
        SRC_PREF = 2'd2
    } rd_src_e;

    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_BOOST_MSHR = 2'd1,
        ST_BOOST_PREF = 2'd2
    } rd_sched_state_e;

endpackage

// File: rtl/icache_rd_out_reg.sv
// Single-entry output register toward the dataram read port; loads on a
// grant, drains on rdy, and holds payload/source stable while stalled.
module icache_rd_out_reg
    import toy_pack::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic            drain_i,
    input  dataram_rd_pld_t pld_i,
    input  logic [1:0]      src_i,
    output logic            vld_o,
    output dataram_rd_pld_t pld_o,
    output logic [1:0]      src_o
);

    logic            vld_q, vld_d;
    dataram_rd_pld_t pld_q, pld_d;
    logic [1:0]      src_q, src_d;

    always_comb begin
        vld_d = vld_q;
        pld_d = pld_q;
        src_d = src_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d = 1'b1;
            pld_d = pld_i;
            src_d = src_i;
        end else if (drain_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            pld_q <= '0;
            src_q <= 2'd0;
        end else begin
            vld_q <= vld_d;
            pld_q <= pld_d;
            src_q <= src_d;
        end
    end

    assign vld_o = vld_q;
    assign pld_o = pld_q;
    assign src_o = src_q;

endmodule

// File: rtl/icache_dataram_rd_sched.sv
// Dataram read scheduler: picks one of hit/mshr/prefetch reads per cycle,
// with starvation counters that boost a losing requester for one grant.
module icache_dataram_rd_sched
    import toy_pack::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hit_rd_vld,
    output logic            hit_rd_rdy,
    input  dataram_rd_pld_t hit_rd_pld,
    input  logic            mshr_rd_vld,
    output logic            mshr_rd_rdy,
    input  dataram_rd_pld_t mshr_rd_pld,
    input  logic            pref_rd_vld,
    output logic            pref_rd_rdy,
    input  dataram_rd_pld_t pref_rd_pld,
    input  logic            wr_busy,
    input  logic            flush,
    output logic            dataram_rd_vld,
    input  logic            dataram_rd_rdy,
    output dataram_rd_pld_t dataram_rd_pld,
    output logic [1:0]      dataram_rd_src
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CMAX  = '1;

    rd_sched_state_e  state_q, state_d;
    logic [CNT_W-1:0] starve_mshr_q, starve_mshr_d;
    logic [CNT_W-1:0] starve_pref_q, starve_pref_d;

    logic            out_vld;
    logic            grant_en;
    logic [2:0]      gnt;
    rd_src_e         gnt_src;
    dataram_rd_pld_t gnt_pld;

    // Grant needs the output slot free or draining this cycle; rst_n gating
    // keeps every rdy low for the whole reset window.
    assign grant_en = rst_n & ~wr_busy & ~flush & (~out_vld | dataram_rd_rdy);

    always_comb begin
        gnt = 3'b000;
        if (grant_en) begin
            unique case (state_q)
                ST_BOOST_MSHR: begin
                    if      (mshr_rd_vld) gnt = 3'b010;
                    else if (hit_rd_vld)  gnt = 3'b001;
                    else if (pref_rd_vld) gnt = 3'b100;
                end
                ST_BOOST_PREF: begin
                    if      (pref_rd_vld) gnt = 3'b100;
                    else if (hit_rd_vld)  gnt = 3'b001;
                    else if (mshr_rd_vld) gnt = 3'b010;
                end
                default: begin
                    if      (hit_rd_vld)  gnt = 3'b001;
                    else if (mshr_rd_vld) gnt = 3'b010;
                    else if (pref_rd_vld) gnt = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        gnt_src = SRC_HIT;
        gnt_pld = hit_rd_pld;
        if (gnt[1]) begin
            gnt_src = SRC_MSHR;
            gnt_pld = mshr_rd_pld;
        end else if (gnt[2]) begin
            gnt_src = SRC_PREF;
            gnt_pld = pref_rd_pld;
        end
    end

    assign hit_rd_rdy  = gnt[0];
    assign mshr_rd_rdy = gnt[1];
    assign pref_rd_rdy = gnt[2];

    always_comb begin
        starve_mshr_d = starve_mshr_q;
        starve_pref_d = starve_pref_q;
        if (flush || !mshr_rd_vld || gnt[1]) starve_mshr_d = '0;
        else if (starve_mshr_q != CMAX)      starve_mshr_d = starve_mshr_q + 1'b1;
        if (flush || !pref_rd_vld || gnt[2]) starve_pref_d = '0;
        else if (starve_pref_q != CMAX)      starve_pref_d = starve_pref_q + 1'b1;
    end

    // Thresholds look at the post-update count so the boost lands on the
    // cycle right after the limit-th lost cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_NORMAL: begin
                if      (starve_mshr_d >= LIMIT) state_d = ST_BOOST_MSHR;
                else if (starve_pref_d >= LIMIT) state_d = ST_BOOST_PREF;
            end
            ST_BOOST_MSHR: if (gnt[1] || !mshr_rd_vld) state_d = ST_NORMAL;
            ST_BOOST_PREF: if (gnt[2] || !pref_rd_vld) state_d = ST_NORMAL;
            default:       state_d = ST_NORMAL;
        endcase
        if (flush) state_d = ST_NORMAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_NORMAL;
            starve_mshr_q <= '0;
            starve_pref_q <= '0;
        end else begin
            state_q       <= state_d;
            starve_mshr_q <= starve_mshr_d;
            starve_pref_q <= starve_pref_d;
        end
    end

    icache_rd_out_reg u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .load_i  (|gnt),
        .drain_i (dataram_rd_rdy),
        .pld_i   (gnt_pld),
        .src_i   (gnt_src),
        .vld_o   (out_vld),
        .pld_o   (dataram_rd_pld),
        .src_o   (dataram_rd_src)
    );

    assign dataram_rd_vld = out_vld;

endmodule

// File: tb/tb_icache_dataram_rd_sched.sv
// Bench for icache_dataram_rd_sched: grant table, directed starvation /
// stall / flush / reset sequences, and a randomized run against a model.
module tb_icache_dataram_rd_sched;
    import toy_pack::*;

    localparam int LIMIT = 8;
    localparam int PLD_W = $bits(dataram_rd_pld_t);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hit_rd_vld = 0, mshr_rd_vld = 0, pref_rd_vld = 0;
    logic            hit_rd_rdy, mshr_rd_rdy, pref_rd_rdy;
    dataram_rd_pld_t hit_rd_pld = '0, mshr_rd_pld = '0, pref_rd_pld = '0;
    logic            wr_busy = 0, flush = 0;
    logic            dataram_rd_vld;
    logic            dataram_rd_rdy = 0;
    dataram_rd_pld_t dataram_rd_pld;
    logic [1:0]      dataram_rd_src;

    icache_dataram_rd_sched #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .hit_rd_vld(hit_rd_vld), .hit_rd_rdy(hit_rd_rdy), .hit_rd_pld(hit_rd_pld),
        .mshr_rd_vld(mshr_rd_vld), .mshr_rd_rdy(mshr_rd_rdy), .mshr_rd_pld(mshr_rd_pld),
        .pref_rd_vld(pref_rd_vld), .pref_rd_rdy(pref_rd_rdy), .pref_rd_pld(pref_rd_pld),
        .wr_busy(wr_busy), .flush(flush),
        .dataram_rd_vld(dataram_rd_vld), .dataram_rd_rdy(dataram_rd_rdy),
        .dataram_rd_pld(dataram_rd_pld), .dataram_rd_src(dataram_rd_src)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    // Reference model: a slot (valid/payload/source), per-requester wait
    // counts, and which requester (if any) currently holds the boost.
    bit              m_vld;
    dataram_rd_pld_t m_pld;
    int              m_src;
    int              m_wait[3];
    int              m_boost;

    logic [2:0] s_rdy;
    logic       s_vld;
    logic [1:0] s_src;
    int         s_pld;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_vld = 0; m_pld = '0; m_src = 0;
        m_wait = '{0, 0, 0}; m_boost = 0;
    endtask

    function automatic int pick(input int bst, input bit [2:0] v);
        int order[3];
        case (bst)
            1:       order = '{1, 0, 2};
            2:       order = '{2, 0, 1};
            default: order = '{0, 1, 2};
        endcase
        for (int k = 0; k < 3; k++) if (v[order[k]]) return order[k];
        return -1;
    endfunction

    // Inputs are driven at the negedge before calling; rdy is checked just
    // after, registered outputs at the following negedge.
    task automatic tick();
        bit [2:0]        v;
        bit              ok;
        int              win;
        dataram_rd_pld_t pl[3];
        #1;
        v     = {pref_rd_vld, mshr_rd_vld, hit_rd_vld};
        pl[0] = hit_rd_pld; pl[1] = mshr_rd_pld; pl[2] = pref_rd_pld;
        ok    = !wr_busy && !flush && (!m_vld || dataram_rd_rdy);
        win   = ok ? pick(m_boost, v) : -1;
        s_rdy = {pref_rd_rdy, mshr_rd_rdy, hit_rd_rdy};
        chk("x_rd_rdy", int'(s_rdy), (win >= 0) ? (1 << win) : 0);
        if (flush) begin
            m_vld = 0; m_wait = '{0, 0, 0}; m_boost = 0;
        end else begin
            if (win >= 0) begin
                m_vld = 1; m_pld = pl[win]; m_src = win;
            end else if (dataram_rd_rdy) m_vld = 0;
            for (int r = 1; r < 3; r++)
                m_wait[r] = (!v[r] || win == r) ? 0 : (m_wait[r] < 15 ? m_wait[r] + 1 : 15);
            if (m_boost != 0) begin
                if (win == m_boost || !v[m_boost]) m_boost = 0;
            end else if (m_wait[1] >= LIMIT) m_boost = 1;
            else if (m_wait[2] >= LIMIT) m_boost = 2;
        end
        @(posedge clk);
        @(negedge clk);
        s_vld = dataram_rd_vld; s_src = dataram_rd_src; s_pld = int'(dataram_rd_pld);
        chk("dataram_rd_vld", int'(s_vld), int'(m_vld));
        if (m_vld) begin
            chk("dataram_rd_pld", s_pld, int'(m_pld));
            chk("dataram_rd_src", int'(s_src), m_src);
        end
    endtask

    task automatic set_vld(input bit h, input bit m, input bit p);
        hit_rd_vld = h; mshr_rd_vld = m; pref_rd_vld = p;
    endtask

    task automatic do_flush();
        set_vld(0, 0, 0); wr_busy = 0; flush = 1; tick(); flush = 0;
    endtask

    typedef struct {
        bit       hv, mv, pv, wb;
        bit [2:0] exp_rdy;
        bit       exp_vld;
        bit [1:0] exp_src;
    } vec_t;

    vec_t tbl[8];
    int   seq_exp[11];

    initial begin
        tbl[0] = '{1, 1, 1, 0, 3'b001, 1, 2'd0};
        tbl[1] = '{0, 1, 1, 0, 3'b010, 1, 2'd1};
        tbl[2] = '{0, 0, 1, 0, 3'b100, 1, 2'd2};
        tbl[3] = '{1, 0, 1, 0, 3'b001, 1, 2'd0};
        tbl[4] = '{0, 0, 0, 0, 3'b000, 0, 2'd0};
        tbl[5] = '{1, 1, 1, 1, 3'b000, 0, 2'd0};
        tbl[6] = '{0, 1, 0, 0, 3'b010, 1, 2'd1};
        tbl[7] = '{1, 1, 0, 0, 3'b001, 1, 2'd0};
        seq_exp = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 1, 4};

        model_reset();
        hit_rd_pld  = dataram_rd_pld_t'(PLD_W'(12'h111));
        mshr_rd_pld = dataram_rd_pld_t'(PLD_W'(12'h222));
        pref_rd_pld = dataram_rd_pld_t'(PLD_W'(12'h333));
        set_vld(1, 1, 1);
        repeat (2) @(negedge clk);
        chk("reset_rdy", int'({pref_rd_rdy, mshr_rd_rdy, hit_rd_rdy}), 0);
        chk("reset_vld", int'(dataram_rd_vld), 0);
        chk("reset_pld", int'(dataram_rd_pld), 0);
        chk("reset_src", int'(dataram_rd_src), 0);
        set_vld(0, 0, 0);
        rst_n = 1;
        dataram_rd_rdy = 1;

        // Single-cycle grant table from a clean NORMAL/empty state.
        for (int i = 0; i < 8; i++) begin
            do_flush();
            set_vld(tbl[i].hv, tbl[i].mv, tbl[i].pv);
            wr_busy = tbl[i].wb;
            tick();
            chk("tbl_rdy", int'(s_rdy), int'(tbl[i].exp_rdy));
            chk("tbl_vld", int'(s_vld), int'(tbl[i].exp_vld));
            if (tbl[i].exp_vld) chk("tbl_src", int'(s_src), int'(tbl[i].exp_src));
        end

        // All three pending: hit x8, mshr boosted once, hit, then pref boosted.
        do_flush();
        set_vld(1, 1, 1);
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("starve_seq_rdy", int'(s_rdy), seq_exp[i]);
            if (i == 8) chk("starve_seq_src", int'(s_src), 1);
            if (i == 10) chk("starve_seq_src", int'(s_src), 2);
        end

        // Back-pressure: output held 5 cycles, then one transfer per cycle.
        do_flush();
        set_vld(1, 0, 0);
        hit_rd_pld = dataram_rd_pld_t'(PLD_W'(12'hA5A));
        tick();
        dataram_rd_rdy = 0;
        hit_rd_pld = dataram_rd_pld_t'(PLD_W'(12'h0B0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_rdy", int'(s_rdy), 0);
            chk("stall_vld", int'(s_vld), 1);
            chk("stall_pld", s_pld, 12'hA5A);
        end
        dataram_rd_rdy = 1;
        for (int i = 0; i < 3; i++) begin
            hit_rd_pld = dataram_rd_pld_t'(PLD_W'(12'h100 + i));
            tick();
            chk("drain_rdy", int'(s_rdy), 1);
            chk("drain_pld", s_pld, 12'h100 + i);
        end

        // Linefill write blocks grants for 3 cycles.
        do_flush();
        set_vld(1, 0, 0);
        wr_busy = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wrbusy_rdy", int'(s_rdy), 0);
            chk("wrbusy_vld", int'(s_vld), 0);
        end
        wr_busy = 0;
        tick();
        chk("wrbusy_grant", int'(s_rdy), 1);
        chk("wrbusy_out_vld", int'(s_vld), 1);

        // Flush while full and with pref boosted: counters and boost cleared.
        do_flush();
        set_vld(1, 0, 1);
        repeat (8) tick();
        flush = 1;
        tick();
        chk("flush_rdy", int'(s_rdy), 0);
        chk("flush_vld", int'(s_vld), 0);
        flush = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("post_flush_rdy", int'(s_rdy), (i == 8) ? 4 : 1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            hit_rd_vld     = ($urandom_range(0, 99) < 40);
            mshr_rd_vld    = ($urandom_range(0, 99) < 60);
            pref_rd_vld    = ($urandom_range(0, 99) < 60);
            wr_busy        = ($urandom_range(0, 99) < 15);
            flush          = ($urandom_range(0, 99) < 3);
            dataram_rd_rdy = ($urandom_range(0, 99) < 75);
            hit_rd_pld     = dataram_rd_pld_t'(PLD_W'($urandom));
            mshr_rd_pld    = dataram_rd_pld_t'(PLD_W'($urandom));
            pref_rd_pld    = dataram_rd_pld_t'(PLD_W'($urandom));
            tick();
        end
        flush = 0; wr_busy = 0; dataram_rd_rdy = 1;

        // Asynchronous reset pulse in the middle of traffic.
        set_vld(1, 1, 1);
        hit_rd_pld = dataram_rd_pld_t'(PLD_W'(12'hFFF));
        tick();
        #2 rst_n = 0;
        #1;
        chk("async_rst_vld", int'(dataram_rd_vld), 0);
        chk("async_rst_pld", int'(dataram_rd_pld), 0);
        chk("async_rst_src", int'(dataram_rd_src), 0);
        chk("async_rst_rdy", int'({pref_rd_rdy, mshr_rd_rdy, hit_rd_rdy}), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("post_rst_grant", int'(s_rdy), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/icache_dataram_rd_sched.md
ICACHE_DATARAM_RD_SCHED -- requirements
Module: icache_dataram_rd_sched

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive lost cycles before a waiting low-priority requester is boosted (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 4, meaning starvation counter width.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports hit_rd_vld/hit_rd_rdy  input/output  1/1  hit-path read handshake; hit_rd_pld  input  dataram_rd_pld_t  way/index/txnid.
REQ-006 SHALL have ports mshr_rd_vld/mshr_rd_rdy  input/output  1/1  MSHR-arbitrated read handshake; mshr_rd_pld  input  dataram_rd_pld_t.
REQ-007 SHALL have ports pref_rd_vld/pref_rd_rdy  input/output  1/1  prefetch read handshake; pref_rd_pld  input  dataram_rd_pld_t.
REQ-008 SHALL have port wr_busy  input  1  dataram linefill write active this cycle; no grant issued.
REQ-009 SHALL have port flush  input  1  synchronous discard of output register and boost state.
REQ-010 SHALL have ports dataram_rd_vld/dataram_rd_rdy  output/input  1/1; dataram_rd_pld  output  dataram_rd_pld_t; dataram_rd_src  output  2  (0 hit, 1 mshr, 2 pref).

Function
REQ-011 SHALL grant at most one requester per cycle; grant only when wr_busy=0, flush=0 and output register can accept (empty, or dataram_rd_rdy=1 this cycle).
REQ-012 SHALL drive x_rd_rdy=1 only for the granted requester; transfer occurs on x_rd_vld & x_rd_rdy.
REQ-013 SHALL use priority hit > mshr > pref in state NORMAL.
REQ-014 SHALL keep FSM states NORMAL, BOOST_MSHR, BOOST_PREF; BOOST_x puts x at top priority for exactly one grant, then returns to NORMAL.
REQ-015 SHALL keep per-requester counters starve_mshr/starve_pref (CNT_W bits): increment, saturating, each cycle requester is valid and not granted; clear on its grant or when not valid.
REQ-016 SHALL transition NORMAL->BOOST_MSHR when starve_mshr reaches STARVE_LIMIT; else NORMAL->BOOST_PREF when starve_pref reaches STARVE_LIMIT; mshr wins simultaneous thresholds.
REQ-017 SHALL return BOOST_x->NORMAL if x drops vld before being granted.
REQ-018 SHALL register the granted pld and source: latency 1 cycle from input handshake to dataram_rd_vld.
REQ-019 SHALL hold dataram_rd_pld/src stable while dataram_rd_vld=1 and dataram_rd_rdy=0.
REQ-020 SHALL sustain one read per cycle when dataram_rd_rdy is held high (simultaneous drain and fill).
REQ-021 SHALL, when wr_busy=1, deassert all x_rd_rdy, still count starvation, and keep output register draining normally.
REQ-022 SHALL, on flush, clear dataram_rd_vld next cycle, clear both counters, go to NORMAL, grant nothing that cycle.
REQ-023 SHALL have no combinational path from dataram_rd_rdy to dataram_rd_vld or dataram_rd_pld.

Reset
REQ-024 SHALL reset asynchronously: dataram_rd_vld=0, dataram_rd_pld=0, dataram_rd_src=0, counters=0, FSM=NORMAL.
REQ-025 SHALL keep all x_rd_rdy=0 while rst_n=0; a read in flight at reset assertion is dropped.

Structure
REQ-026 SHALL take dataram_rd_pld_t, ICACHE_INDEX_WIDTH, ICACHE_REQ_TXNID_WIDTH from toy_pack; add rd_src_e (SRC_HIT, SRC_MSHR, SRC_PREF) to toy_pack.
REQ-027 SHALL be a single module; the output register is a natural sub-module candidate, named icache_rd_out_reg.

Verification
REQ-028 SHALL cover: hit, mshr, pref all vld, rdy=1 -> hit granted each cycle; after 8 cycles mshr granted once (src=1), hit resumes.
REQ-029 SHALL cover: mshr and pref both starved 8 cycles simultaneously -> mshr boosted first; pref reaches threshold again and is granted.
REQ-030 SHALL cover: dataram_rd_rdy=0 for 5 cycles with output full -> pld/src unchanged, all x_rd_rdy=0, then one transfer per cycle after rdy=1.
REQ-031 SHALL cover: wr_busy=1 for 3 cycles with hit vld -> hit_rd_rdy=0 for 3 cycles, grant on 4th cycle, dataram_rd_vld on 5th.
REQ-032 SHALL cover: flush with output full and BOOST_PREF -> dataram_rd_vld=0 next cycle, FSM=NORMAL, counters=0; mid-operation rst_n pulse -> all outputs 0 asynchronously.
